ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
- RV32IM execute stage, directly downstream of the ID/EX pipeline register; consumes its pc, instruction, operand, rd, immediate and control outputs.
- Computes ALU results, resolves branches and jumps, and drives the EX/MEM boundary.
- Contains a multi-cycle iterative divider (DIV/DIVU/REM/REMU). While the divider is busy, the stage stalls upstream and has ID/EX flushed.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- DIV_CNT_W, 6, width of the divider iteration counter.

Ports:
- i_Clk  in  1  clock
- i_reset  in  1  asynchronous reset, active-high
- i_pc_addr  in  32  pc of the instruction in EX
- i_inst_data  in  32  instruction; opcode/funct3/funct7 are decoded locally
- i_reg1_data  in  32  rs1 value
- i_reg2_data  in  32  rs2 value
- i_regd_addr  in  5  rd address
- i_imm_data  in  32  sign-extended immediate
- i_ctrl  in  16  control bundle; forwarded unchanged
- o_regd_addr  out  5  rd address to EX/MEM
- o_regd_data  out  32  result
- o_regd_we  out  1  rd write enable
- o_ctrl  out  16  forwarded control
- o_reg2_data  out  32  store data (rs2)
- o_mem_addr  out  32  rs1+imm for loads/stores
- o_jump_flag  out  1  redirect pc this cycle
- o_jump_addr  out  32  redirect target
- o_flush_req  out  1  flush IF/ID and ID/EX
- o_stall_req  out  1  hold pc and IF/ID; flush ID/EX
- o_div_busy  out  1  divider not IDLE

Behaviour:
- Reset (async, i_reset=1): divider state IDLE, counter 0, all internal registers 0. All outputs read 0; NOP passes through with o_regd_we=0.
- Non-divide instructions are single-cycle and combinational from the inputs:
  - OP/OP-IMM: add/sub, sll/srl/sra (shamt=[4:0]), slt/sltu, xor/or/and.
  - LUI: rd=imm. AUIPC: rd=pc+imm.
  - MUL/MULH/MULHSU/MULHU: combinational 64-bit product; select low or high word.
  - Loads/stores: o_mem_addr=rs1+imm; o_regd_we=0 for stores and branches.
  - Arithmetic is modulo 2^32; no overflow traps.
- x0 rule: o_regd_we=0 whenever rd=0.
- Branches (BEQ/BNE/BLT/BGE/BLTU/BGEU) and jumps:
  - Taken branch: o_jump_flag=1, o_jump_addr=pc+imm, o_flush_req=1, all for exactly that cycle.
  - JAL: target pc+imm. JALR: target (rs1+imm)&~1. Both write rd=pc+4 and always redirect.
  - Not-taken branch: all three flags 0.
- Unknown opcodes: treated as NOP (no write, no redirect).
- Divider FSM has states IDLE, CALC, DONE.
- IDLE, divide op presented at cycle T:
  - Latch dividend, divisor, rd, i_ctrl, op sign/rem select.
  - o_stall_req=1 and o_regd_we=0 in cycle T.
  - Divisor==0: quotient=0xFFFFFFFF, remainder=dividend; go to DONE.
  - Signed op with 0x80000000 / 0xFFFFFFFF: quotient=0x80000000, remainder=0; go to DONE.
  - Otherwise: take magnitudes for signed ops, counter=0, go to CALC.
- CALC:
  - One restoring shift-subtract step per cycle for 32 cycles (T+1..T+32).
  - o_stall_req=1 on every CALC cycle.
  - After counter reaches 31, apply sign fix-ups and go to DONE:
    - Quotient negative iff signs differ.
    - Remainder takes the sign of the dividend.
- DONE (T+33 for the normal path, T+1 for the special cases):
  - o_regd_data is the latched result, o_regd_addr/o_ctrl are the latched values, o_regd_we=1 (unless rd=0), o_stall_req=0.
  - Return to IDLE.
- Inputs are ignored while in CALC/DONE; ID/EX holds a NOP then.
  - When stall drops, ID re-issues the held instruction at T+34 (normal path).
- o_div_busy=1 in CALC and DONE.
- Reset mid-divide aborts immediately: IDLE, no write.
- Back-to-back divides: the second enters IDLE at T+34 and begins a fresh sequence. There is no result forwarding between divides.

Optional Feature:
- Macro RV32M_EN.
- Defined: MUL* and DIV*/REM* are implemented as above.
- Undefined:
  - Divider FSM and multiplier are absent.
  - funct7=0000001 OP instructions act as NOP: o_regd_we=0, o_stall_req=0.
  - o_div_busy is tied 0.

Test Plan:
- ADDI x5,x0,-1 (imm=0xFFFFFFFF) -> same cycle: o_regd_data=0xFFFFFFFF, o_regd_addr=5, o_regd_we=1, no jump.
- BEQ, rs1=rs2=7, pc=0x100, imm=0x20 -> o_jump_flag=1, o_jump_addr=0x120, o_flush_req=1 for one cycle. With rs2=8 -> all three 0.
- DIV x3, rs1=-7, rs2=2 -> o_stall_req high T..T+32; at T+33 o_regd_data=0xFFFFFFFD (-3), we=1. REM with the same operands -> 0xFFFFFFFF (-1).
- DIVU, rs2=0, rs1=0x1234 -> stall only in T; T+1 quotient=0xFFFFFFFF. REMU with the same operands -> 0x1234.
- DIV 0x80000000 / 0xFFFFFFFF -> T+1 result 0x80000000, no exception.
- Start DIVU 100/3, assert i_reset at T+10 -> all outputs 0 and state IDLE at once. After release, ADD 1+2 -> 3 with no stall.

Source files
------------

// File: rtl/ex_stage.sv
// RV32IM execute stage: ALU, branch/jump resolution, EX/MEM boundary drive.
// Optional M extension (multiplier + iterative divider) enabled by RV32M_EN.
// Handshake: o_stall_req=1 means upstream must hold pc/IF-ID and insert a NOP
// into ID/EX; the held instruction is re-issued the cycle after stall drops.
module ex_stage #(
    parameter int XLEN      = 32,
    parameter int DIV_CNT_W = 6
) (
    input  logic            i_Clk,
    input  logic            i_reset,
    input  logic [XLEN-1:0] i_pc_addr,
    input  logic [XLEN-1:0] i_inst_data,
    input  logic [XLEN-1:0] i_reg1_data,
    input  logic [XLEN-1:0] i_reg2_data,
    input  logic [4:0]      i_regd_addr,
    input  logic [XLEN-1:0] i_imm_data,
    input  logic [15:0]     i_ctrl,
    output logic [4:0]      o_regd_addr,
    output logic [XLEN-1:0] o_regd_data,
    output logic            o_regd_we,
    output logic [15:0]     o_ctrl,
    output logic [XLEN-1:0] o_reg2_data,
    output logic [XLEN-1:0] o_mem_addr,
    output logic            o_jump_flag,
    output logic [XLEN-1:0] o_jump_addr,
    output logic            o_flush_req,
    output logic            o_stall_req,
    output logic            o_div_busy
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic            is_m_op;
    logic [XLEN-1:0] rs1, rs2, imm;
    logic [XLEN-1:0] sum_ri, pc_imm, pc_4, op_b, alu_fn;
    logic [4:0]      shamt;
    logic            is_sub, br_taken;
    logic [XLEN-1:0] alu_res;
    logic            alu_we, alu_jump;
    logic [XLEN-1:0] alu_jump_addr;
    logic [XLEN-1:0] mul_res;

    assign opcode  = i_inst_data[6:0];
    assign funct3  = i_inst_data[14:12];
    assign funct7  = i_inst_data[31:25];
    assign is_m_op = (opcode == OPC_OP) && (funct7 == 7'b0000001);
    assign rs1     = i_reg1_data;
    assign rs2     = i_reg2_data;
    assign imm     = i_imm_data;
    assign sum_ri  = rs1 + imm;
    assign pc_imm  = i_pc_addr + imm;
    assign pc_4    = i_pc_addr + 32'd4;
    assign op_b    = (opcode == OPC_OP) ? rs2 : imm;
    assign shamt   = op_b[4:0];
    // inst[30] selects SUB (register form only) and SRA/SRAI
    assign is_sub  = (opcode == OPC_OP) && i_inst_data[30];

    // Register/immediate ALU function selected by funct3
    always_comb begin
        alu_fn = '0;
        case (funct3)
            3'b000:  alu_fn = is_sub ? (rs1 - op_b) : (rs1 + op_b);
            3'b001:  alu_fn = rs1 << shamt;
            3'b010:  alu_fn = {31'd0, $signed(rs1) < $signed(op_b)};
            3'b011:  alu_fn = {31'd0, rs1 < op_b};
            3'b100:  alu_fn = rs1 ^ op_b;
            3'b101:  alu_fn = i_inst_data[30] ? $unsigned($signed(rs1) >>> shamt)
                                              : (rs1 >> shamt);
            3'b110:  alu_fn = rs1 | op_b;
            default: alu_fn = rs1 & op_b;
        endcase
    end

    // Branch condition evaluation; reserved funct3 codes never branch
    always_comb begin
        br_taken = 1'b0;
        case (funct3)
            3'b000:  br_taken = (rs1 == rs2);
            3'b001:  br_taken = (rs1 != rs2);
            3'b100:  br_taken = $signed(rs1) <  $signed(rs2);
            3'b101:  br_taken = $signed(rs1) >= $signed(rs2);
            3'b110:  br_taken = rs1 <  rs2;
            3'b111:  br_taken = rs1 >= rs2;
            default: br_taken = 1'b0;
        endcase
    end

    // Single-cycle result, write enable and redirect per opcode
    always_comb begin
        alu_res       = '0;
        alu_we        = 1'b0;
        alu_jump      = 1'b0;
        alu_jump_addr = '0;
        case (opcode)
            OPC_OP: begin
                if (!is_m_op) begin
                    alu_res = alu_fn;
                    alu_we  = 1'b1;
                end else if (!funct3[2]) begin
`ifdef RV32M_EN
                    alu_res = mul_res;
                    alu_we  = 1'b1;
`endif
                end
            end
            OPC_OP_IMM: begin
                alu_res = alu_fn;
                alu_we  = 1'b1;
            end
            OPC_LUI: begin
                alu_res = imm;
                alu_we  = 1'b1;
            end
            OPC_AUIPC: begin
                alu_res = pc_imm;
                alu_we  = 1'b1;
            end
            OPC_JAL: begin
                alu_res       = pc_4;
                alu_we        = 1'b1;
                alu_jump      = 1'b1;
                alu_jump_addr = pc_imm;
            end
            OPC_JALR: begin
                alu_res       = pc_4;
                alu_we        = 1'b1;
                alu_jump      = 1'b1;
                alu_jump_addr = sum_ri & ~32'd1;
            end
            OPC_BRANCH: begin
                alu_jump      = br_taken;
                alu_jump_addr = br_taken ? pc_imm : '0;
            end
            OPC_LOAD: begin
                // the loaded value replaces this in MEM; rd write is still owed
                alu_res = sum_ri;
                alu_we  = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef RV32M_EN
    typedef enum logic [1:0] {DIV_IDLE, DIV_CALC, DIV_DONE} div_state_e;

    localparam logic [DIV_CNT_W-1:0] DIV_LAST = DIV_CNT_W'(XLEN - 1);

    logic [32:0]          mul_a, mul_b;
    logic [65:0]          mul_p;
    logic                 unused_mul;
    div_state_e           state_q;
    logic [DIV_CNT_W-1:0] cnt_q;
    logic [XLEN-1:0]      quot_q, rem_q, divisor_q, result_q;
    logic [4:0]           rd_q;
    logic [15:0]          ctrl_q;
    logic                 is_rem_q, neg_q_q, neg_r_q;
    logic                 div_start, div_signed;
    logic [XLEN-1:0]      a_mag, b_mag;
    logic [32:0]          rem_shift_d, rem_sub_d;
    logic                 step_ge;
    logic [XLEN-1:0]      rem_step_d, quot_step_d, q_fix_d, r_fix_d;

    // MULH treats both operands as signed, MULHSU only rs1, MULHU neither
    assign mul_a = {((funct3 == 3'b001) || (funct3 == 3'b010)) & rs1[31], rs1};
    assign mul_b = {(funct3 == 3'b001) & rs2[31], rs2};
    assign mul_p = {{33{mul_a[32]}}, mul_a} * {{33{mul_b[32]}}, mul_b};
    assign mul_res    = (funct3 == 3'b000) ? mul_p[31:0] : mul_p[63:32];
    assign unused_mul = ^mul_p[65:64];

    assign div_start  = (state_q == DIV_IDLE) && is_m_op && funct3[2];
    assign div_signed = !funct3[0];
    assign a_mag      = (div_signed && rs1[31]) ? (32'd0 - rs1) : rs1;
    assign b_mag      = (div_signed && rs2[31]) ? (32'd0 - rs2) : rs2;

    // One restoring step: shift the next dividend bit into the partial remainder
    always_comb begin
        rem_shift_d = {rem_q, quot_q[31]};
        rem_sub_d   = rem_shift_d - {1'b0, divisor_q};
        step_ge     = rem_shift_d >= {1'b0, divisor_q};
        rem_step_d  = step_ge ? rem_sub_d[31:0] : rem_shift_d[31:0];
        quot_step_d = {quot_q[30:0], step_ge};
        q_fix_d     = neg_q_q ? (32'd0 - quot_step_d) : quot_step_d;
        r_fix_d     = neg_r_q ? (32'd0 - rem_step_d) : rem_step_d;
    end

    // Divider FSM: IDLE latches the op, CALC iterates 32 steps, DONE presents result
    always_ff @(posedge i_Clk or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= DIV_IDLE;
            cnt_q     <= '0;
            quot_q    <= '0;
            rem_q     <= '0;
            divisor_q <= '0;
            result_q  <= '0;
            rd_q      <= '0;
            ctrl_q    <= '0;
            is_rem_q  <= 1'b0;
            neg_q_q   <= 1'b0;
            neg_r_q   <= 1'b0;
        end else begin
            case (state_q)
                DIV_IDLE: begin
                    if (div_start) begin
                        rd_q     <= i_regd_addr;
                        ctrl_q   <= i_ctrl;
                        is_rem_q <= funct3[1];
                        if (rs2 == '0) begin
                            result_q <= funct3[1] ? rs1 : '1;
                            state_q  <= DIV_DONE;
                        end else if (div_signed && (rs1 == 32'h8000_0000) &&
                                     (rs2 == 32'hFFFF_FFFF)) begin
                            result_q <= funct3[1] ? 32'd0 : 32'h8000_0000;
                            state_q  <= DIV_DONE;
                        end else begin
                            quot_q    <= a_mag;
                            rem_q     <= '0;
                            divisor_q <= b_mag;
                            neg_q_q   <= div_signed && (rs1[31] ^ rs2[31]);
                            neg_r_q   <= div_signed && rs1[31];
                            cnt_q     <= '0;
                            state_q   <= DIV_CALC;
                        end
                    end
                end
                DIV_CALC: begin
                    quot_q <= quot_step_d;
                    rem_q  <= rem_step_d;
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == DIV_LAST) begin
                        result_q <= is_rem_q ? r_fix_d : q_fix_d;
                        cnt_q    <= '0;
                        state_q  <= DIV_DONE;
                    end
                end
                DIV_DONE: state_q <= DIV_IDLE;
                default:  state_q <= DIV_IDLE;
            endcase
        end
    end
`else
    logic unused_clk;
    assign mul_res    = '0;
    assign unused_clk = i_Clk ^ ^mul_res;
`endif

    logic unused_inst;
    assign unused_inst = ^{i_inst_data[24:15], i_inst_data[11:7]};

    // EX/MEM drive: single-cycle path, overridden by divider state and reset
    always_comb begin
        o_regd_addr = i_regd_addr;
        o_regd_data = alu_res;
        o_regd_we   = alu_we && (i_regd_addr != 5'd0);
        o_ctrl      = i_ctrl;
        o_reg2_data = rs2;
        o_mem_addr  = sum_ri;
        o_jump_flag = alu_jump;
        o_jump_addr = alu_jump_addr;
        o_flush_req = alu_jump;
        o_stall_req = 1'b0;
        o_div_busy  = 1'b0;
`ifdef RV32M_EN
        case (state_q)
            DIV_IDLE: begin
                if (div_start) begin
                    o_regd_data = '0;
                    o_regd_we   = 1'b0;
                    o_stall_req = 1'b1;
                end
            end
            DIV_CALC: begin
                o_regd_data = '0;
                o_regd_we   = 1'b0;
                o_jump_flag = 1'b0;
                o_jump_addr = '0;
                o_flush_req = 1'b0;
                o_stall_req = 1'b1;
                o_div_busy  = 1'b1;
            end
            DIV_DONE: begin
                o_regd_addr = rd_q;
                o_regd_data = result_q;
                o_regd_we   = (rd_q != 5'd0);
                o_ctrl      = ctrl_q;
                o_jump_flag = 1'b0;
                o_jump_addr = '0;
                o_flush_req = 1'b0;
                o_div_busy  = 1'b1;
            end
            default: ;
        endcase
`endif
        if (i_reset) begin
            o_regd_addr = '0;
            o_regd_data = '0;
            o_regd_we   = 1'b0;
            o_ctrl      = '0;
            o_reg2_data = '0;
            o_mem_addr  = '0;
            o_jump_flag = 1'b0;
            o_jump_addr = '0;
            o_flush_req = 1'b0;
            o_stall_req = 1'b0;
            o_div_busy  = 1'b0;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage; M-extension checks follow RV32M_EN.
module tb_ex_stage;

  logic        i_Clk = 1'b0;
  logic        i_reset = 1'b1;
  logic [31:0] i_pc_addr = '0, i_inst_data = '0, i_reg1_data = '0, i_reg2_data = '0;
  logic [4:0]  i_regd_addr = '0;
  logic [31:0] i_imm_data = '0;
  logic [15:0] i_ctrl = '0;
  logic [4:0]  o_regd_addr;
  logic [31:0] o_regd_data, o_reg2_data, o_mem_addr, o_jump_addr;
  logic        o_regd_we, o_jump_flag, o_flush_req, o_stall_req, o_div_busy;
  logic [15:0] o_ctrl;

  int n_cmp = 0;
  int n_err = 0;

  ex_stage dut (
    .i_Clk(i_Clk), .i_reset(i_reset), .i_pc_addr(i_pc_addr), .i_inst_data(i_inst_data),
    .i_reg1_data(i_reg1_data), .i_reg2_data(i_reg2_data), .i_regd_addr(i_regd_addr),
    .i_imm_data(i_imm_data), .i_ctrl(i_ctrl), .o_regd_addr(o_regd_addr),
    .o_regd_data(o_regd_data), .o_regd_we(o_regd_we), .o_ctrl(o_ctrl),
    .o_reg2_data(o_reg2_data), .o_mem_addr(o_mem_addr), .o_jump_flag(o_jump_flag),
    .o_jump_addr(o_jump_addr), .o_flush_req(o_flush_req), .o_stall_req(o_stall_req),
    .o_div_busy(o_div_busy)
  );

  // clock / reset block
  always #5 i_Clk = ~i_Clk;

  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3,
                                     input logic [6:0] op);
    return {f7, 10'd0, f3, 5'd0, op};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // driver tasks: inputs change 1 time unit after the active edge
  task automatic drive(input logic [31:0] pc, input logic [31:0] inst, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input logic [31:0] imm,
                       input logic [15:0] ctrl);
    i_pc_addr = pc; i_inst_data = inst; i_reg1_data = a; i_reg2_data = b;
    i_regd_addr = rd; i_imm_data = imm; i_ctrl = ctrl;
    #1;
  endtask

  task automatic nop();
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic next_cycle();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic chk_res(input string tag, input logic [31:0] data, input logic we,
                         input logic [4:0] rd);
    chk({tag, "_data"}, o_regd_data, data);
    chk({tag, "_we"}, {31'd0, o_regd_we}, {31'd0, we});
    chk({tag, "_rd"}, {27'd0, o_regd_addr}, {27'd0, rd});
    chk({tag, "_stall"}, {31'd0, o_stall_req}, 32'd0);
  endtask

  task automatic chk_jump(input string tag, input logic j, input logic [31:0] addr);
    chk({tag, "_jf"}, {31'd0, o_jump_flag}, {31'd0, j});
    chk({tag, "_ja"}, o_jump_addr, addr);
    chk({tag, "_fl"}, {31'd0, o_flush_req}, {31'd0, j});
  endtask

`ifdef RV32M_EN
  // present a divide at T, then count stall cycles (bounded) and check DONE
  task automatic run_div(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                         input int exp_stalls);
    int n;
    drive(0, mk(7'b0000001, f3, 7'b0110011), a, b, rd, 0, 16'h5A5A);
    chk({tag, "_T_stall"}, {31'd0, o_stall_req}, 32'd1);
    chk({tag, "_T_we"}, {31'd0, o_regd_we}, 32'd0);
    next_cycle();
    nop();
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (!o_stall_req) break;
      n++;
      next_cycle();
    end
    chk({tag, "_stalls"}, n, exp_stalls);
    chk_res(tag, exp, 1'b1, rd);
    chk({tag, "_busy"}, {31'd0, o_div_busy}, 32'd1);
    chk({tag, "_ctrl"}, {16'd0, o_ctrl}, 32'h5A5A);
    next_cycle();
    chk({tag, "_idle"}, {31'd0, o_div_busy}, 32'd0);
  endtask
`endif

  // directed stimulus and scoreboard
  initial begin
    #1;
    chk("rst_data", o_regd_data, 0);
    chk("rst_we", {31'd0, o_regd_we}, 0);
    chk("rst_busy", {31'd0, o_div_busy}, 0);
    next_cycle();
    i_reset = 1'b0;
    nop();
    chk_res("nop", 0, 1'b0, 0);

    drive(0, mk(7'd0, 3'b000, 7'b0010011), 0, 0, 5, 32'hFFFF_FFFF, 16'hABCD);
    chk_res("addi", 32'hFFFF_FFFF, 1'b1, 5);
    chk_jump("addi", 1'b0, 0);
    chk("ctrl", {16'd0, o_ctrl}, 32'hABCD);
    drive(0, mk(7'd0, 3'b000, 7'b0110011), 1, 2, 6, 0, 0);
    chk_res("add", 3, 1'b1, 6);
    drive(0, mk(7'b0100000, 3'b000, 7'b0110011), 5, 7, 6, 0, 0);
    chk_res("sub", 32'hFFFF_FFFE, 1'b1, 6);
    drive(0, mk(7'd0, 3'b010, 7'b0110011), 32'hFFFF_FFFF, 1, 7, 0, 0);
    chk_res("slt", 1, 1'b1, 7);
    drive(0, mk(7'd0, 3'b011, 7'b0110011), 32'hFFFF_FFFF, 1, 7, 0, 0);
    chk_res("sltu", 0, 1'b1, 7);
    drive(0, mk(7'b0100000, 3'b101, 7'b0010011), 32'h8000_0000, 0, 8, 32'h404, 0);
    chk_res("srai", 32'hF800_0000, 1'b1, 8);
    drive(0, mk(7'd0, 3'b101, 7'b0010011), 32'h8000_0000, 0, 8, 32'h4, 0);
    chk_res("srli", 32'h0800_0000, 1'b1, 8);
    drive(0, mk(7'd0, 3'b001, 7'b0110011), 1, 32'h25, 9, 0, 0);
    chk_res("sll", 32'h20, 1'b1, 9);
    drive(0, mk(7'd0, 3'b111, 7'b0110011), 32'hF0F0, 32'hFF00, 9, 0, 0);
    chk_res("and", 32'hF000, 1'b1, 9);
    drive(0, mk(7'd0, 3'b000, 7'b0110111), 0, 0, 4, 32'h1234_5000, 0);
    chk_res("lui", 32'h1234_5000, 1'b1, 4);
    drive(32'h100, mk(7'd0, 3'b000, 7'b0010111), 0, 0, 4, 32'h1000, 0);
    chk_res("auipc", 32'h1100, 1'b1, 4);
    drive(0, mk(7'd0, 3'b010, 7'b0100011), 32'h1000, 32'hCAFE, 0, 32'h10, 0);
    chk("sw_addr", o_mem_addr, 32'h1010);
    chk("sw_wdata", o_reg2_data, 32'hCAFE);
    chk("sw_we", {31'd0, o_regd_we}, 0);
    drive(0, mk(7'd0, 3'b000, 7'b0110011), 1, 2, 0, 0, 0);
    chk("x0_we", {31'd0, o_regd_we}, 0);
    drive(0, mk(7'd0, 3'b000, 7'b1111111), 1, 2, 3, 0, 0);
    chk_res("unk", 0, 1'b0, 3);
    chk_jump("unk", 1'b0, 0);

    drive(32'h100, mk(7'd0, 3'b000, 7'b1100011), 7, 7, 0, 32'h20, 0);
    chk_jump("beq_t", 1'b1, 32'h120);
    chk("beq_we", {31'd0, o_regd_we}, 0);
    next_cycle();
    nop();
    chk_jump("beq_after", 1'b0, 0);
    drive(32'h100, mk(7'd0, 3'b000, 7'b1100011), 7, 8, 0, 32'h20, 0);
    chk_jump("beq_nt", 1'b0, 0);
    drive(32'h100, mk(7'd0, 3'b100, 7'b1100011), 32'hFFFF_FFFF, 1, 0, 32'h20, 0);
    chk_jump("blt_t", 1'b1, 32'h120);
    drive(32'h100, mk(7'd0, 3'b110, 7'b1100011), 32'hFFFF_FFFF, 1, 0, 32'h20, 0);
    chk_jump("bltu_nt", 1'b0, 0);
    drive(32'h200, mk(7'd0, 3'b000, 7'b1101111), 0, 0, 1, 32'h40, 0);
    chk_jump("jal", 1'b1, 32'h240);
    chk_res("jal", 32'h204, 1'b1, 1);
    drive(32'h200, mk(7'd0, 3'b000, 7'b1100111), 32'h301, 0, 1, 32'h4, 0);
    chk_jump("jalr", 1'b1, 32'h304);
    chk_res("jalr", 32'h204, 1'b1, 1);
    next_cycle();

`ifdef RV32M_EN
    drive(0, mk(7'b0000001, 3'b000, 7'b0110011), 3, 32'hFFFF_FFFE, 2, 0, 0);
    chk_res("mul", 32'hFFFF_FFFA, 1'b1, 2);
    drive(0, mk(7'b0000001, 3'b001, 7'b0110011), 32'hFFFF_FFFE, 3, 2, 0, 0);
    chk_res("mulh", 32'hFFFF_FFFF, 1'b1, 2);
    drive(0, mk(7'b0000001, 3'b010, 7'b0110011), 32'hFFFF_FFFF, 2, 2, 0, 0);
    chk_res("mulhsu", 32'hFFFF_FFFF, 1'b1, 2);
    drive(0, mk(7'b0000001, 3'b011, 7'b0110011), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 0, 0);
    chk_res("mulhu", 32'hFFFF_FFFE, 1'b1, 2);
    run_div("div", 3'b100, 32'hFFFF_FFF9, 2, 3, 32'hFFFF_FFFD, 32);
    run_div("rem", 3'b110, 32'hFFFF_FFF9, 2, 3, 32'hFFFF_FFFF, 32);
    run_div("divu0", 3'b101, 32'h1234, 0, 4, 32'hFFFF_FFFF, 0);
    run_div("remu0", 3'b111, 32'h1234, 0, 4, 32'h1234, 0);
    run_div("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5, 32'h8000_0000, 0);
    run_div("divu", 3'b101, 100, 3, 6, 33, 32);
    run_div("remu", 3'b111, 100, 3, 6, 1, 32);
`else
    drive(0, mk(7'b0000001, 3'b000, 7'b0110011), 3, 5, 2, 0, 0);
    chk_res("mul_off", 0, 1'b0, 2);
    drive(0, mk(7'b0000001, 3'b100, 7'b0110011), 32'hFFFF_FFF9, 2, 3, 0, 0);
    chk_res("div_off", 0, 1'b0, 3);
    chk("div_off_busy", {31'd0, o_div_busy}, 0);
`endif

    // reset in the middle of a divide aborts it at once
    drive(0, mk(7'b0000001, 3'b101, 7'b0110011), 100, 3, 6, 0, 16'h0F0F);
    next_cycle();
    nop();
    for (int i = 0; i < 9; i++) next_cycle();
    i_reset = 1'b1;
    #1;
    chk("mid_rst_busy", {31'd0, o_div_busy}, 0);
    chk("mid_rst_stall", {31'd0, o_stall_req}, 0);
    chk("mid_rst_we", {31'd0, o_regd_we}, 0);
    chk("mid_rst_data", o_regd_data, 0);
    next_cycle();
    i_reset = 1'b0;
    drive(0, mk(7'd0, 3'b000, 7'b0110011), 1, 2, 7, 0, 0);
    chk_res("post_rst_add", 3, 1'b1, 7);
    chk("post_rst_busy", {31'd0, o_div_busy}, 0);
    next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
